cas_sort_pipe: RTL and testbench

//  Parametrised, pipelined odd-even transposition sorter over NUM_INPUTS unsigned lanes.

---
 rtl/cas_sort_pipe_pkg.sv | 26 ++
 rtl/cas_sort_pipe_if.sv | 30 +++
 rtl/cas_sort_pipe_cell.sv | 27 ++
 rtl/cas_sort_pipe.sv | 102 ++++++++++
 tb/tb_cas_sort_pipe.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cas_sort_pipe_pkg.sv
// Shared constants, lane type and network-shape helpers for the CAS sorter.
package cas_sort_pipe_pkg;

    localparam int SNG_WIDTH_DEF  = 8;
    localparam int NUM_INPUTS_DEF = 4;

    typedef logic [SNG_WIDTH_DEF-1:0] lane_t;

    // Even stages pair (0,1),(2,3)...; odd stages pair (1,2),(3,4)...
    function automatic int pair_start(input int stage);
        return stage % 2;
    endfunction

    // Lane is the lower member of a compared pair in this stage.
    function automatic bit is_pair_lo(input int stage, input int lane, input int n);
        int p;
        p = pair_start(stage);
        return (lane >= p) && (((lane - p) % 2) == 0) && (lane + 1 < n);
    endfunction

    // Lane is the upper member of a compared pair in this stage.
    function automatic bit is_pair_hi(input int stage, input int lane, input int n);
        return (lane >= 1) && is_pair_lo(stage, lane - 1, n);
    endfunction

endpackage

// File: rtl/cas_sort_pipe_if.sv
// Streaming bus of the sorter: input vector handshake and sorted output handshake.
interface cas_sort_pipe_if
    import cas_sort_pipe_pkg::*;
#(
    parameter int NUM_INPUTS = NUM_INPUTS_DEF,
    parameter int SNG_WIDTH  = SNG_WIDTH_DEF
) ();

    logic                            in_valid;
    logic                            in_ready;
    logic                            in_descend;
    logic [NUM_INPUTS*SNG_WIDTH-1:0] in_data;
    logic                            out_valid;
    logic                            out_ready;
    logic                            out_descend;
    logic [NUM_INPUTS*SNG_WIDTH-1:0] out_data;

    // Source of vectors and sink of sorted results.
    modport master (
        output in_valid, in_descend, in_data, out_ready,
        input  in_ready, out_valid, out_descend, out_data
    );

    // The sorter itself.
    modport slave (
        input  in_valid, in_descend, in_data, out_ready,
        output in_ready, out_valid, out_descend, out_data
    );

endinterface

// File: rtl/cas_sort_pipe_cell.sv
// Combinational 2-lane compare-and-swap; ties never swap so equal keys stay put.
module cas_cell #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         descend,
    output logic [W-1:0] lo_lane,
    output logic [W-1:0] hi_lane
);

    logic [W:0] diff;
    logic       a_lt_b;
    logic       a_gt_b;
    logic       swap;

    // Borrow of the widened subtraction gives a<b; nonzero without borrow gives a>b.
    always_comb begin
        diff    = {1'b0, a} - {1'b0, b};
        a_lt_b  = diff[W];
        a_gt_b  = ~diff[W] & (|diff[W-1:0]);
        swap    = descend ? a_lt_b : a_gt_b;
        lo_lane = swap ? b : a;
        hi_lane = swap ? a : b;
    end

endmodule

// File: rtl/cas_sort_pipe.sv
// Pipelined odd-even transposition sorter: NUM_INPUTS registered CAS stages with
// an elastic valid/ready chain and a direction bit riding along with each vector.
module cas_sort_pipe
    import cas_sort_pipe_pkg::*;
#(
    parameter int NUM_INPUTS = NUM_INPUTS_DEF,
    parameter int SNG_WIDTH  = SNG_WIDTH_DEF
) (
    input  logic           clk,
    input  logic           rst,
    cas_sort_pipe_if.slave bus
);

    localparam int N = NUM_INPUTS;
    localparam int W = SNG_WIDTH;

    typedef logic [N-1:0][W-1:0] vec_t;

    vec_t         stage_data [N];
    logic [N-1:0] vld_pipe;
    logic [N-1:0] stage_desc;
    logic [N-1:0] rdy;   // content of stage s may leave this cycle
    logic [N-1:0] adv;   // stage s may load this cycle

    // Ready chain, walked from the output back: a stage loads when empty or draining.
    always_comb begin
        rdy = '0;
        adv = '0;
        rdy[N-1] = bus.out_ready;
        for (int s = N - 1; s >= 0; s--) begin
            adv[s] = ~vld_pipe[s] | rdy[s];
            if (s > 0) rdy[s-1] = adv[s];
        end
    end

    assign bus.in_ready    = adv[0];
    assign bus.out_valid   = vld_pipe[N-1];
    assign bus.out_descend = stage_desc[N-1];
    assign bus.out_data    = stage_data[N-1];

    for (genvar s = 0; s < N; s++) begin : g_stage
        vec_t         src;
        logic         src_vld;
        logic         src_desc;
        logic [W-1:0] nxt [N];
        vec_t         nxt_p;
        vec_t         data_q;
        logic         vld_q;
        logic         desc_q;

        if (s == 0) begin : g_head
            assign src      = bus.in_data;
            assign src_vld  = bus.in_valid;
            assign src_desc = bus.in_descend;
        end else begin : g_body
            assign src      = stage_data[s-1];
            assign src_vld  = vld_pipe[s-1];
            assign src_desc = stage_desc[s-1];
        end

        // Pairs start at lane 0 on even stages, lane 1 on odd; end lanes left unpaired pass through.
        for (genvar i = 0; i < N; i++) begin : g_lane
            if (is_pair_lo(s, i, N)) begin : g_cas
                cas_cell #(.W(W)) u_cas (
                    .a       (src[i]),
                    .b       (src[i+1]),
                    .descend (src_desc),
                    .lo_lane (nxt[i]),
                    .hi_lane (nxt[i+1])
                );
            end else if (!is_pair_hi(s, i, N)) begin : g_pass
                assign nxt[i] = src[i];
            end
        end

        // Repack lane results into the stage register format.
        always_comb begin
            nxt_p = '0;
            for (int i = 0; i < N; i++) nxt_p[i] = nxt[i];
        end

        // Stage register: valid follows the predecessor on load; data only moves with a real vector.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q  <= 1'b0;
                desc_q <= 1'b0;
                data_q <= '0;
            end else if (adv[s]) begin
                vld_q <= src_vld;
                if (src_vld) begin
                    desc_q <= src_desc;
                    data_q <= nxt_p;
                end
            end
        end

        assign vld_pipe[s]   = vld_q;
        assign stage_desc[s] = desc_q;
        assign stage_data[s] = data_q;
    end

endmodule

// File: tb/tb_cas_sort_pipe.sv
// Directed bench for cas_sort_pipe in two shapes: 4x8-bit and 5x12-bit lanes.
module tb_cas_sort_pipe;

    logic clk;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    cas_sort_pipe_if #(.NUM_INPUTS(4), .SNG_WIDTH(8))  ifa ();
    cas_sort_pipe_if #(.NUM_INPUTS(5), .SNG_WIDTH(12)) ifb ();

    cas_sort_pipe #(.NUM_INPUTS(4), .SNG_WIDTH(8))  u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
    cas_sort_pipe #(.NUM_INPUTS(5), .SNG_WIDTH(12)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int lanes_of(input int d);
        return (d == 0) ? 4 : 5;
    endfunction

    function automatic int width_of(input int d);
        return (d == 0) ? 8 : 12;
    endfunction

    task automatic set_in(input int d, input bit v, input bit dsc, input logic [63:0] x);
        if (d == 0) begin
            ifa.in_valid = v; ifa.in_descend = dsc; ifa.in_data = x[31:0];
        end else begin
            ifb.in_valid = v; ifb.in_descend = dsc; ifb.in_data = x[59:0];
        end
    endtask

    task automatic set_ordy(input int d, input bit r);
        if (d == 0) ifa.out_ready = r;
        else        ifb.out_ready = r;
    endtask

    function automatic bit o_valid(input int d);
        return (d == 0) ? ifa.out_valid : ifb.out_valid;
    endfunction

    function automatic bit o_desc(input int d);
        return (d == 0) ? ifa.out_descend : ifb.out_descend;
    endfunction

    function automatic bit i_ready(input int d);
        return (d == 0) ? ifa.in_ready : ifb.in_ready;
    endfunction

    function automatic logic [63:0] o_data(input int d);
        return (d == 0) ? 64'(ifa.out_data) : 64'(ifb.out_data);
    endfunction

    function automatic logic [63:0] pk4(input int l0, l1, l2, l3);
        return {32'd0, 8'(l3), 8'(l2), 8'(l1), 8'(l0)};
    endfunction

    function automatic logic [63:0] pk5(input int l0, l1, l2, l3, l4);
        return {4'd0, 12'(l4), 12'(l3), 12'(l2), 12'(l1), 12'(l0)};
    endfunction

    // Plain sort of the lanes, used as the reference for random streams.
    function automatic logic [63:0] ref_sort(input int d, input logic [63:0] v, input bit dsc);
        int n, w, t;
        int l [5];
        logic [63:0] r;
        n = lanes_of(d);
        w = width_of(d);
        for (int i = 0; i < n; i++) l[i] = int'((v >> (i * w)) & ((64'd1 << w) - 1));
        for (int p = 0; p < n; p++)
            for (int i = 0; i < n - 1; i++)
                if (dsc ? (l[i] < l[i+1]) : (l[i] > l[i+1])) begin
                    t = l[i]; l[i] = l[i+1]; l[i+1] = t;
                end
        r = '0;
        for (int i = 0; i < n; i++) r = r | (64'(l[i]) << (i * w));
        return r;
    endfunction

    function automatic logic [63:0] rnd_vec(input int d);
        logic [63:0] v;
        int w, mx;
        w  = width_of(d);
        mx = ($urandom_range(0, 3) == 0) ? 3 : (1 << w) - 1;
        v  = '0;
        for (int i = 0; i < lanes_of(d); i++) v = v | (64'($urandom_range(0, mx)) << (i * w));
        return v;
    endfunction

    // Push one vector with an idle pipe and check latency, data and direction.
    task automatic send_and_wait(input int d, input logic [63:0] x, input bit dsc,
                                 input logic [63:0] exp, input string tag);
        int cnt;
        set_ordy(d, 1'b1);
        set_in(d, 1'b1, dsc, x);
        #1;
        chk({tag, "_in_ready"}, 64'(i_ready(d)), 64'd1);
        step();
        set_in(d, 1'b0, 1'b0, '0);
        cnt = 1;
        while (!o_valid(d) && cnt < 20) begin
            step();
            cnt++;
        end
        chk({tag, "_latency"}, 64'(cnt), 64'(lanes_of(d)));
        chk({tag, "_data"}, o_data(d), exp);
        chk({tag, "_desc"}, 64'(o_desc(d)), 64'(dsc));
        step();
    endtask

    // Stream nvec vectors through, optionally stalling the sink over [stall_lo, stall_hi).
    task automatic run_stream(input int d, input int nvec, input int stall_lo, input int stall_hi,
                              input bit alt_dir, input string tag);
        logic [63:0] exp_q [$];
        logic [63:0] cur_v, e, held;
        bit          cur_dir, holding, saw_drop, ordy;
        int          sent, got, cyc;
        sent = 0; got = 0; cyc = 0;
        holding = 0; saw_drop = 0; held = '0;
        cur_v   = rnd_vec(d);
        cur_dir = alt_dir ? 1'b0 : 1'($urandom_range(0, 1));
        while (got < nvec && cyc < 300) begin
            ordy = !(cyc >= stall_lo && cyc < stall_hi);
            set_ordy(d, ordy);
            if (sent < nvec) set_in(d, 1'b1, cur_dir, cur_v);
            else             set_in(d, 1'b0, 1'b0, '0);
            #1;
            if (o_valid(d) && ordy) begin
                if (exp_q.size() == 0) begin
                    chk({tag, "_unexpected"}, 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk({tag, "_data"}, o_data(d), {1'b0, e[62:0]});
                    chk({tag, "_desc"}, 64'(o_desc(d)), 64'(e[63]));
                end
                got++;
            end
            if (o_valid(d) && !ordy) begin
                if (holding) chk({tag, "_hold"}, o_data(d), held);
                held    = o_data(d);
                holding = 1;
            end else begin
                holding = 0;
            end
            if (sent < nvec && !i_ready(d)) saw_drop = 1;
            if (sent < nvec && i_ready(d)) begin
                e = ref_sort(d, cur_v, cur_dir);
                e[63] = cur_dir;
                exp_q.push_back(e);
                sent++;
                cur_v   = rnd_vec(d);
                cur_dir = alt_dir ? 1'(sent % 2) : 1'($urandom_range(0, 1));
            end
            step();
            cyc++;
        end
        chk({tag, "_count"}, 64'(got), 64'(nvec));
        chk({tag, "_left"}, 64'(exp_q.size()), 64'd0);
        if (stall_hi > stall_lo) chk({tag, "_in_ready_drop"}, 64'(saw_drop), 64'd1);
        set_in(d, 1'b0, 1'b0, '0);
        set_ordy(d, 1'b1);
    endtask

    // Two vectors in flight, then reset: nothing may emerge, and the pipe must work after.
    task automatic reset_mid(input int d, input logic [63:0] x, input logic [63:0] exp, input string tag);
        bit saw;
        set_ordy(d, 1'b1);
        set_in(d, 1'b1, 1'b0, x);
        step();
        set_in(d, 1'b1, 1'b1, x);
        step();
        set_in(d, 1'b0, 1'b0, '0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        saw = 0;
        for (int k = 0; k < 8; k++) begin
            saw = saw | o_valid(d);
            step();
        end
        chk({tag, "_dropped"}, 64'(saw), 64'd0);
        send_and_wait(d, x, 1'b0, exp, {tag, "_post"});
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 1'b1, 1'b1, pk4(9, 8, 7, 6));
        set_in(1, 1'b1, 1'b1, pk5(9, 8, 7, 6, 5));
        set_ordy(0, 1'b1);
        set_ordy(1, 1'b1);
        step(); step(); step();
        for (int d = 0; d < 2; d++) begin
            chk("rst_out_valid", 64'(o_valid(d)), 64'd0);
            chk("rst_out_data", o_data(d), 64'd0);
            chk("rst_out_desc", 64'(o_desc(d)), 64'd0);
        end
        rst = 1'b0;
        set_in(0, 1'b0, 1'b0, '0);
        set_in(1, 1'b0, 1'b0, '0);
        step();
        chk("rst_in_ready_a", 64'(i_ready(0)), 64'd1);
        chk("rst_in_ready_b", 64'(i_ready(1)), 64'd1);

        // 4 lanes x 8 bits
        send_and_wait(0, pk4(200, 3, 77, 3),    1'b0, pk4(3, 3, 77, 200),    "a_asc");
        send_and_wait(0, pk4(200, 3, 77, 3),    1'b1, pk4(200, 77, 3, 3),    "a_desc");
        send_and_wait(0, pk4(0, 255, 128, 255), 1'b0, pk4(0, 128, 255, 255), "a_ext_asc");
        send_and_wait(0, pk4(0, 255, 128, 255), 1'b1, pk4(255, 255, 128, 0), "a_ext_desc");
        send_and_wait(0, pk4(5, 5, 5, 5),       1'b0, pk4(5, 5, 5, 5),       "a_ties");
        run_stream(0, 8, 3, 9, 1'b0, "a_bp");
        run_stream(0, 6, 0, 0, 1'b1, "a_mix");
        reset_mid(0, pk4(9, 1, 250, 4), pk4(1, 4, 9, 250), "a_rst");

        // 5 lanes x 12 bits
        send_and_wait(1, pk5(4095, 0, 2048, 7, 2048), 1'b0, pk5(0, 7, 2048, 2048, 4095), "b_asc");
        send_and_wait(1, pk5(4095, 0, 2048, 7, 2048), 1'b1, pk5(4095, 2048, 2048, 7, 0), "b_desc");
        send_and_wait(1, pk5(1, 4095, 0, 4095, 1),    1'b0, pk5(0, 1, 1, 4095, 4095),    "b_ext_asc");
        run_stream(1, 8, 3, 9, 1'b0, "b_bp");
        run_stream(1, 6, 0, 0, 1'b1, "b_mix");
        reset_mid(1, pk5(300, 20, 1000, 5, 20), pk5(5, 20, 20, 300, 1000), "b_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
